// File: rtl/rpt_ctrl.sv
// rpt_ctrl: hardware repeat-loop controller holding a stack of nested loop descriptors.
// Optional macro RPT_ERR_EN adds a sticky rpt_err flag for overflow / end<start pushes.
`ifndef IMEMADDRW
`define IMEMADDRW 16
`endif

module rpt_ctrl #(
    parameter int AW    = `IMEMADDRW,
    parameter int CNT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     t_cs,
    input  logic                     lock_rq,
    input  logic                     pc_init_en,
    input  logic                     jmp_pc_sel,
    input  logic [AW-1:0]            mv_PC,
    input  logic                     rpt_set,
    input  logic [AW-1:0]            rpt_start_i,
    input  logic [AW-1:0]            rpt_end_i,
    input  logic [CNT_W-1:0]         rpt_cnt_i,
    output logic                     rpt_again,
    output logic [AW-1:0]            rpt_start_addr,
    output logic                     rpt_busy,
    output logic [$clog2(DEPTH):0]   rpt_depth
`ifdef RPT_ERR_EN
    ,
    output logic                     rpt_err
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam int DW = IW + 1;

    logic [AW-1:0]    r_start [DEPTH];
    logic [AW-1:0]    r_end   [DEPTH];
    logic [CNT_W-1:0] r_rem   [DEPTH];
    logic [DW-1:0]    r_depth;

    logic [IW-1:0]    w_top;
    logic [IW-1:0]    w_push_idx;
    logic [CNT_W-1:0] w_push_cnt;
    logic             w_busy;
    logic             w_hit;
    logic             w_step;
    logic             w_dec;
    logic             w_pop;
    logic             w_full;
    logic             w_illegal;
    logic             w_push;

    // Top index wraps harmlessly when empty; every use is gated by w_busy.
    always_comb begin
        w_top      = r_depth[IW-1:0] - 1'b1;
        w_busy     = (r_depth != '0);
        w_hit      = w_busy && (mv_PC == r_end[w_top]);
        w_step     = t_cs && !lock_rq && !pc_init_en && !jmp_pc_sel;
        w_dec      = w_step && w_hit && (r_rem[w_top] > CNT_W'(1));
        w_pop      = w_step && w_hit && (r_rem[w_top] <= CNT_W'(1));
        w_full     = (r_depth == DW'(DEPTH));
`ifdef RPT_ERR_EN
        w_illegal  = (rpt_end_i < rpt_start_i);
`else
        w_illegal  = 1'b0;
`endif
        w_push     = t_cs && rpt_set && !pc_init_en && !w_full && !w_illegal;
        // A push coincident with a pop reuses the slot just vacated.
        w_push_idx = w_pop ? w_top : r_depth[IW-1:0];
        w_push_cnt = (rpt_cnt_i == '0) ? CNT_W'(1) : rpt_cnt_i;
    end

    always_comb begin
        rpt_again      = w_dec;
        rpt_start_addr = w_busy ? r_start[w_top] : '0;
        rpt_busy       = w_busy;
        rpt_depth      = r_depth;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_depth <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_start[i] <= '0;
                r_end[i]   <= '0;
                r_rem[i]   <= '0;
            end
        end else if (t_cs) begin
            if (pc_init_en) begin
                r_depth <= '0;
            end else begin
                if (w_dec)
                    r_rem[w_top] <= r_rem[w_top] - 1'b1;
                if (w_push) begin
                    r_start[w_push_idx] <= rpt_start_i;
                    r_end[w_push_idx]   <= rpt_end_i;
                    r_rem[w_push_idx]   <= w_push_cnt;
                end
                if (w_pop && !w_push)
                    r_depth <= r_depth - 1'b1;
                else if (w_push && !w_pop)
                    r_depth <= r_depth + 1'b1;
            end
        end
    end

`ifdef RPT_ERR_EN
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rpt_err <= 1'b0;
        end else if (t_cs) begin
            if (pc_init_en)
                rpt_err <= 1'b0;
            else if (rpt_set && (w_full || w_illegal))
                rpt_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rpt_ctrl.sv
// tb_rpt_ctrl: directed loop scenarios plus randomized traffic, checked against a
// queue-based loop-stack model; rpt_err is compared when RPT_ERR_EN is defined.
module tb_rpt_ctrl;

    localparam int AW    = 16;
    localparam int CNT_W = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_b;
    logic             t_cs, lock_rq, pc_init_en, jmp_pc_sel, rpt_set;
    logic [AW-1:0]    mv_PC, rpt_start_i, rpt_end_i;
    logic [CNT_W-1:0] rpt_cnt_i;
    logic             rpt_again, rpt_busy;
    logic [AW-1:0]    rpt_start_addr;
    logic [$clog2(DEPTH):0] rpt_depth;
`ifdef RPT_ERR_EN
    logic             rpt_err;
`endif

    always #5 clk = ~clk;

    rpt_ctrl #(.AW(AW), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_b(reset_b), .t_cs(t_cs), .lock_rq(lock_rq),
        .pc_init_en(pc_init_en), .jmp_pc_sel(jmp_pc_sel), .mv_PC(mv_PC),
        .rpt_set(rpt_set), .rpt_start_i(rpt_start_i), .rpt_end_i(rpt_end_i),
        .rpt_cnt_i(rpt_cnt_i), .rpt_again(rpt_again), .rpt_start_addr(rpt_start_addr),
        .rpt_busy(rpt_busy), .rpt_depth(rpt_depth)
`ifdef RPT_ERR_EN
        , .rpt_err(rpt_err)
`endif
    );

    typedef struct { int s; int e; int rem; } loop_t;
    typedef struct { int pc; int s; int e; int c; } push_t;

    loop_t stk[$];
    int    m_err;
    int    n_checks = 0;
    int    n_fail   = 0;

    bit    obs_again;
    bit    exp_again_v;
    int    exp_sa_v;
    push_t pt[$];
    int    exec_cnt[256];
    int    dep_log[$];
    int    n_again;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_step();
        return t_cs && !lock_rq && !pc_init_en && !jmp_pc_sel;
    endfunction

    function automatic bit m_hit();
        return (stk.size() > 0) && (int'(mv_PC) == stk[$].e);
    endfunction

    function automatic bit m_again();
        return m_step() && m_hit() && (stk[$].rem > 1);
    endfunction

    function automatic int m_sa();
        return (stk.size() > 0) ? stk[$].s : 0;
    endfunction

    task automatic m_update();
        int    sz;
        bit    illegal;
        loop_t t;
        sz      = stk.size();
        illegal = 1'b0;
        if (t_cs) begin
            if (pc_init_en) begin
                stk.delete();
                m_err = 0;
            end else begin
                if (m_step() && m_hit()) begin
                    if (stk[$].rem > 1) begin
                        t = stk[$];
                        t.rem = t.rem - 1;
                        stk[stk.size()-1] = t;
                    end else begin
                        void'(stk.pop_back());
                    end
                end
                if (rpt_set) begin
`ifdef RPT_ERR_EN
                    illegal = int'(rpt_end_i) < int'(rpt_start_i);
                    if (illegal || sz == DEPTH) m_err = 1;
`endif
                    if (!illegal && sz < DEPTH) begin
                        t.s   = int'(rpt_start_i);
                        t.e   = int'(rpt_end_i);
                        t.rem = (rpt_cnt_i == 0) ? 1 : int'(rpt_cnt_i);
                        stk.push_back(t);
                    end
                end
            end
        end
    endtask

    // Inputs are driven at the falling edge; outputs are sampled 2 time units later.
    task automatic do_cycle();
        #2;
        check_val("rpt_again", rpt_again, m_again());
        check_val("rpt_start_addr", rpt_start_addr, m_sa());
        check_val("rpt_busy", rpt_busy, stk.size() > 0);
        check_val("rpt_depth", rpt_depth, stk.size());
`ifdef RPT_ERR_EN
        check_val("rpt_err", rpt_err, m_err);
`endif
        obs_again   = rpt_again;
        exp_again_v = m_again();
        exp_sa_v    = m_sa();
        m_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        t_cs = 1'b1; lock_rq = 1'b0; pc_init_en = 1'b0; jmp_pc_sel = 1'b0; rpt_set = 1'b0;
    endtask

    task automatic drive_push(input int s, input int e, input int c);
        rpt_set = 1'b1; rpt_start_i = AW'(s); rpt_end_i = AW'(e); rpt_cnt_i = CNT_W'(c);
    endtask

    task automatic flush();
        set_idle();
        pc_init_en = 1'b1;
        do_cycle();
        pc_init_en = 1'b0;
    endtask

    // Sequential fetch with loop-back taken from the model; decode pushes at table PCs.
    task automatic run_prog(input int pc0, input int pc_stop, input int budget);
        int pc;
        int cyc;
        int last_depth;
        pc = pc0; cyc = 0; n_again = 0;
        foreach (exec_cnt[i]) exec_cnt[i] = 0;
        dep_log.delete();
        last_depth = int'(rpt_depth);
        while (pc != pc_stop && cyc < budget) begin
            set_idle();
            mv_PC = AW'(pc);
            foreach (pt[i]) if (pt[i].pc == pc) drive_push(pt[i].s, pt[i].e, pt[i].c);
            exec_cnt[pc & 255]++;
            do_cycle();
            if (obs_again) n_again++;
            if (int'(rpt_depth) != last_depth) begin
                last_depth = int'(rpt_depth);
                dep_log.push_back(last_depth);
            end
            pc = exp_again_v ? exp_sa_v : pc + 1;
            cyc++;
        end
        check_val("prog_reached_exit", cyc < budget, 1'b1);
        set_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_dep[6];
        int cnt_pulses;
        exp_dep = '{1, 2, 1, 2, 1, 0};
        m_err = 0;
        reset_b = 1'b0;
        t_cs = 1'b0; lock_rq = 1'b0; pc_init_en = 1'b0; jmp_pc_sel = 1'b0; rpt_set = 1'b0;
        mv_PC = '0; rpt_start_i = '0; rpt_end_i = '0; rpt_cnt_i = '0;
        @(negedge clk); @(negedge clk);
        #2;
        check_val("reset_again", rpt_again, 1'b0);
        check_val("reset_start_addr", rpt_start_addr, 0);
        check_val("reset_busy", rpt_busy, 1'b0);
        check_val("reset_depth", rpt_depth, 0);
`ifdef RPT_ERR_EN
        check_val("reset_err", rpt_err, 1'b0);
`endif
        @(negedge clk);
        reset_b = 1'b1;
        set_idle();

        // Single loop, three passes.
        pt.delete();
        pt.push_back('{32'h0F, 32'h10, 32'h12, 3});
        run_prog(32'h0F, 32'h13, 50);
        check_val("single_pulses", n_again, 2);
        check_val("single_body_passes", exec_cnt[32'h12], 3);
        check_val("single_busy_after", rpt_busy, 1'b0);

        // Nested loops.
        pt.delete();
        pt.push_back('{32'h1F, 32'h20, 32'h28, 2});
        pt.push_back('{32'h21, 32'h22, 32'h24, 3});
        run_prog(32'h1F, 32'h29, 200);
        check_val("nest_inner_passes", exec_cnt[32'h22], 6);
        check_val("nest_outer_passes", exec_cnt[32'h20], 2);
        check_val("nest_depth_changes", dep_log.size(), 6);
        foreach (exp_dep[i])
            check_val("nest_depth_seq", (i < dep_log.size()) ? dep_log[i] : -1, exp_dep[i]);

        // Lock and chip-select hold at the end address.
        cnt_pulses = 0;
        set_idle(); mv_PC = 16'h3F; drive_push(32'h40, 32'h42, 2); do_cycle();
        set_idle(); mv_PC = 16'h42; lock_rq = 1'b1;
        for (int i = 0; i < 3; i++) begin do_cycle(); cnt_pulses += int'(obs_again); end
        lock_rq = 1'b0; t_cs = 1'b0;
        for (int i = 0; i < 3; i++) begin do_cycle(); cnt_pulses += int'(obs_again); end
        t_cs = 1'b1;
        for (int pc = 32'h42; pc >= 32'h40; pc = (pc == 32'h42 && exp_again_v) ? 32'h40 : pc + 1) begin
            if (pc > 32'h42) break;
            mv_PC = AW'(pc); do_cycle(); cnt_pulses += int'(obs_again);
            if (!exp_again_v && pc == 32'h42) break;
        end
        check_val("hold_pulses", cnt_pulses, 1);
        check_val("hold_busy_after", rpt_busy, 1'b0);

        // Overflow: five pushes into a four-deep stack.
        flush();
        mv_PC = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            drive_push(32'h100 + i * 16, 32'h104 + i * 16, 2); do_cycle();
        end
        set_idle(); #2;
        check_val("ovf_depth", rpt_depth, 4);
        check_val("ovf_top_start", rpt_start_addr, 16'h130);
`ifdef RPT_ERR_EN
        check_val("ovf_err_set", rpt_err, 1'b1);
        do_cycle();
        check_val("ovf_err_held", rpt_err, 1'b1);
`endif
        @(negedge clk);
        flush(); #2;
        check_val("ovf_flush_depth", rpt_depth, 0);
`ifdef RPT_ERR_EN
        check_val("ovf_err_cleared", rpt_err, 1'b0);
`endif
        @(negedge clk);

        // Jump at end address leaves the count alone; pc_init flushes mid-loop.
        set_idle(); mv_PC = 16'h4F; drive_push(32'h50, 32'h52, 3); do_cycle();
        set_idle(); mv_PC = 16'h52; jmp_pc_sel = 1'b1; do_cycle();
        check_val("jump_no_again", obs_again, 1'b0);
        jmp_pc_sel = 1'b0; do_cycle();
        check_val("jump_pass1_again", obs_again, 1'b1);
        do_cycle();
        check_val("jump_pass2_again", obs_again, 1'b1);
        check_val("jump_busy_midloop", rpt_busy, 1'b1);
        mv_PC = 16'h51; pc_init_en = 1'b1; do_cycle();
        pc_init_en = 1'b0; #2;
        check_val("init_busy_cleared", rpt_busy, 1'b0);
        check_val("init_depth_cleared", rpt_depth, 0);
        @(negedge clk);

        // Corner counts 0 and 1.
        for (int c = 0; c < 2; c++) begin
            pt.delete();
            pt.push_back('{32'h5F, 32'h60, 32'h62, c});
            run_prog(32'h5F, 32'h63, 20);
            check_val("corner_cnt_pulses", n_again, 0);
            check_val("corner_cnt_passes", exec_cnt[32'h62], 1);
            check_val("corner_cnt_busy", rpt_busy, 1'b0);
        end

        // Push coincident with pop.
        set_idle(); mv_PC = 16'h6F; drive_push(32'h70, 32'h71, 1); do_cycle();
        set_idle(); mv_PC = 16'h70; do_cycle();
        mv_PC = 16'h71; drive_push(32'h80, 32'h85, 2); do_cycle();
        set_idle(); #2;
        check_val("coinc_depth", rpt_depth, 1);
        check_val("coinc_top_start", rpt_start_addr, 16'h80);
        @(negedge clk);

        // Randomized traffic against the model.
        flush();
        for (int n = 0; n < 3000; n++) begin
            int s;
            t_cs       = ($urandom_range(0, 9) != 0);
            lock_rq    = ($urandom_range(0, 9) == 0);
            pc_init_en = ($urandom_range(0, 39) == 0);
            jmp_pc_sel = ($urandom_range(0, 19) == 0);
            rpt_set    = ($urandom_range(0, 5) == 0);
            s          = $urandom_range(0, 12);
            rpt_start_i = AW'(s);
            rpt_end_i   = AW'(s + $urandom_range(0, 3));
            rpt_cnt_i   = CNT_W'($urandom_range(0, 4));
            mv_PC       = AW'($urandom_range(0, 15));
            do_cycle();
        end
        set_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rpt_ctrl.md
Name: rpt_ctrl

Overview:
- Hardware loop (repeat) controller for the Tcore instruction fetch unit.
- Holds a small stack of nested repeat descriptors (start addr, end addr, remaining count), one per repeat instruction issued by decode.
- Compares each descriptor against the current fetch PC and drives rpt_again/rpt_start_addr into the PC FSM, so loop bodies re-execute with no branch overhead.

Parameters:
- AW, `IMEMADDRW, instruction memory address width (matches mv_PC)
- CNT_W, 16, iteration count width
- DEPTH, 4, maximum nesting depth (power of 2, ≥2)

Ports:
- clk  in  1  system clock
- reset_b  in  1  asynchronous active-low reset
- t_cs  in  1  core select; low = freeze all state
- lock_rq  in  1  pipeline lock; PC holds, no loop action
- pc_init_en  in  1  PC initialise; flushes loop stack
- jmp_pc_sel  in  1  jump taken this cycle; suppresses loop-back
- mv_PC  in  AW  current fetch PC from PC FSM
- rpt_set  in  1  decode pulse: push new loop
- rpt_start_i  in  AW  first body instruction address
- rpt_end_i  in  AW  last body instruction address
- rpt_cnt_i  in  CNT_W  body execution count
- rpt_again  out  1  loop-back request to PC FSM
- rpt_start_addr  out  AW  loop-back target (top-of-stack start)
- rpt_busy  out  1  stack non-empty
- rpt_depth  out  log2(DEPTH)+1  current stack occupancy

Behaviour:
- Reset:
  - Stack empty, depth 0, all descriptor registers 0.
  - rpt_busy=0; rpt_again=0; rpt_start_addr=0.
- Stack: DEPTH entries {start, end, remaining}. Only the top entry is active.
- "Step" = t_cs & !lock_rq & !pc_init_en & !jmp_pc_sel. No state changes unless t_cs=1.
- Hit = busy & (mv_PC == top.end).
- rpt_again = Step & hit & (top.remaining > 1). This path is combinational from registers and inputs, with zero latency. The PC FSM loads rpt_start_addr on the same clock edge.
- rpt_start_addr = top.start when busy, else 0.
- On Step & hit:
  - If remaining > 1: decrement remaining by 1.
  - If remaining ≤ 1: pop; the next lower entry becomes top. rpt_again is not asserted, so fetch falls through to end+1.
- Push on rpt_set & t_cs:
  - New entry {rpt_start_i, rpt_end_i, rpt_cnt_i} goes above the current top; depth increments.
  - rpt_cnt_i=0 is treated as 1: the body executes once, then the entry pops.
  - rpt_set is honoured even during lock_rq.
- Simultaneous hit-action and push in the same cycle: apply the hit action (decrement or pop) to the old top first, then push. Net depth is unchanged on pop+push.
- Full: rpt_set with depth==DEPTH is ignored. The stack is unchanged.
- Underflow is impossible: hit requires busy.
- pc_init_en & t_cs: stack flushed (depth 0), same cycle, with priority over push.
- jmp_pc_sel: no decrement and no pop. A loop exited by jump stays stacked until pc_init_en or until its end address is next fetched.
- Nesting rule: an inner loop must not share an end address with an enclosing loop. If it does, only the top entry is serviced, and the outer iteration is lost on that pass.
- Count arithmetic is unsigned CNT_W with no wrap. Decrement only occurs when remaining>1.

Optional Feature:
- Macro: RPT_ERR_EN.
- When defined:
  - Adds output rpt_err (1 bit), reset 0.
  - rpt_err is sticky and set when a push is attempted at depth==DEPTH.
  - It is also set when a push has rpt_end_i < rpt_start_i.
  - It is cleared only by reset or by pc_init_en.
  - An illegal push (end<start) is additionally discarded.
- When undefined: no rpt_err port. Overflow pushes are silently dropped. end<start pushes are stored, and behaviour is then undefined.

Test Plan:
- Single loop: push start=0x10, end=0x12, cnt=3; PC runs sequentially.
  - rpt_again pulses when mv_PC=0x12 on the 1st and 2nd passes, with rpt_start_addr=0x10.
  - 3rd pass: no pulse, entry pops, rpt_busy→0, PC reaches 0x13.
- Nested loops: outer {0x20,0x28,2}, inner {0x22,0x24,3}.
  - Body 0x22–0x24 executes 6 times in total.
  - 0x20–0x28 executes twice.
  - rpt_depth sequence is 1→2→1→2→1→0.
- Lock and chip-select hold: assert lock_rq, then separately t_cs=0, while mv_PC=end with cnt=2.
  - No rpt_again and no decrement.
  - After release, exactly one loop-back occurs.
- Overflow: push 5 loops with DEPTH=4.
  - 5th push is ignored; depth stays 4.
  - With RPT_ERR_EN, rpt_err=1 until pc_init_en.
- Flush and jump:
  - Jump taken at mv_PC=end (jmp_pc_sel=1): rpt_again=0 and remaining is unchanged.
  - pc_init_en mid-loop: depth→0 and rpt_busy=0 the next cycle.
- Corner counts:
  - cnt=0 and cnt=1 each give a single pass with no rpt_again.
  - rpt_set coincident with a pop at mv_PC=end: final depth is unchanged and the new top is the pushed entry.
